// File: rtl/chan_gen_pkg.sv
// Shared types and helpers for channel_code_gen: symbol type, PRBS7 step, accumulator sizing, code conversion.
// CHANNEL_CODE_GEN_SAT_EN selects saturating output conversion; otherwise codes wrap.
package chan_gen_pkg;

  typedef logic signed [1:0] sym_t;

  localparam logic [6:0] PRBS7_RESET_STATE = 7'h01;

  function automatic int acc_w(input int est_w, input int depth);
    return est_w + 2 + $clog2(depth);
  endfunction

  function automatic int num_past_words(input int depth, input int lanes);
    int n;
    n = (depth - 1 + lanes - 1) / lanes;
    return (n < 1) ? 1 : n;
  endfunction

  function automatic sym_t sym_of(input logic b);
    return b ? 2'sb01 : 2'sb11;
  endfunction

  // x^7+x^6+1: returns {output bit, next state}; the output bit is also shifted in
  function automatic logic [7:0] prbs7_step(input logic [6:0] state);
    logic fb;
    fb = state[6] ^ state[5];
    return {fb, state[5:0], fb};
  endfunction

  function automatic logic signed [31:0] code_conv(input logic signed [31:0] acc, input int code_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (code_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
`ifdef CHANNEL_CODE_GEN_SAT_EN
    if (acc > hi) begin
      return hi;
    end else if (acc < lo) begin
      return lo;
    end else begin
      return acc;
    end
`else
    return acc & ((hi <<< 1) | 32'sd1);
`endif
  endfunction

endpackage

// File: rtl/chan_fir_lane.sv
// One lane's +/-1 symbol dot product against its channel taps (add/subtract/skip per tap).
module chan_fir_lane #(
  parameter int estBitwidth = 8,
  parameter int estDepth    = 11,
  parameter int accWidth    = 14
) (
  input  logic [2*estDepth-1:0]                  syms,
  input  logic [estDepth-1:0][estBitwidth-1:0]   est,
  output logic signed [accWidth-1:0]             acc
);

  logic signed [accWidth-1:0] tap;

  // symbol 01 adds the tap, 11 subtracts it, 00 (pre-reset history) contributes nothing
  always_comb begin
    acc = '0;
    tap = '0;
    for (int k = 0; k < estDepth; k++) begin
      tap = accWidth'($signed(est[k]));
      if (syms[2*k +: 2] == 2'b01) begin
        acc = acc + tap;
      end else if (syms[2*k +: 2] == 2'b11) begin
        acc = acc - tap;
      end else begin
        acc = acc;
      end
    end
  end

endmodule

// File: rtl/channel_code_gen.sv
// Bit source (bits_in or PRBS7) convolved with per-lane channel taps into ADC-style codes, 2-clk latency.
// Define CHANNEL_CODE_GEN_SAT_EN for saturating codes; default build wraps to codeBitwidth bits.
module channel_code_gen
  import chan_gen_pkg::*;
#(
  parameter int numChannels  = 32,
  parameter int codeBitwidth = 8,
  parameter int estBitwidth  = 8,
  parameter int estDepth     = 11
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              in_valid,
  input  logic                                              use_prbs,
  input  logic                                              seed_load,
  input  logic [6:0]                                        prbs_seed,
  input  logic [numChannels-1:0]                            bits_in,
  input  logic [numChannels-1:0][estDepth-1:0][estBitwidth-1:0] channel_est,
  output logic [numChannels-1:0][codeBitwidth-1:0]          codes,
  output logic [numChannels-1:0]                            bits_out,
  output logic                                              out_valid
);

  localparam int ACC_W = acc_w(estBitwidth, estDepth);
  localparam int PAST  = num_past_words(estDepth, numChannels);
  // only the newest estDepth-1 symbols of the past words can ever reach a tap
  localparam int HIST      = (PAST * numChannels < estDepth - 1) ? PAST * numChannels : estDepth - 1;
  localparam int HIST_BITS = 2 * HIST;

  logic [6:0]                               lfsr;
  logic [6:0]                               lfsr_next;
  logic [7:0]                               step;
  logic [numChannels-1:0]                   prbs_word;
  logic [numChannels-1:0]                   word;
  logic [2*numChannels-1:0]                 cur_syms;
  logic [HIST_BITS-1:0]                     hist;
  logic [HIST_BITS-1:0]                     hist_next;
  logic [HIST_BITS-1:0]                     snap;
  logic [numChannels-1:0]                   cur_bits;
  logic [2*numChannels-1:0]                 cur_win;
  logic [2*(HIST+numChannels)-1:0]          win;
  logic                                     v1;
  logic [numChannels-1:0][codeBitwidth-1:0] codes_next;

  // unroll numChannels PRBS7 steps; lane 0 takes the first output bit
  always_comb begin
    lfsr_next = lfsr;
    step      = '0;
    prbs_word = '0;
    for (int l = 0; l < numChannels; l++) begin
      step         = prbs7_step(lfsr_next);
      prbs_word[l] = step[7];
      lfsr_next    = step[6:0];
    end
  end

  // source select and +/-1 symbol mapping for the incoming and registered words
  always_comb begin
    if (use_prbs) begin
      word = prbs_word;
    end else begin
      word = bits_in;
    end
    cur_syms = '0;
    cur_win  = '0;
    for (int l = 0; l < numChannels; l++) begin
      cur_syms[2*l +: 2] = sym_of(word[l]);
      cur_win[2*l +: 2]  = sym_of(cur_bits[l]);
    end
  end

  assign hist_next = HIST_BITS'({cur_syms, hist} >> (2 * numChannels));
  assign win       = {cur_win, snap};

  // stage 1: LFSR, symbol history and word capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr     <= PRBS7_RESET_STATE;
      hist     <= '0;
      snap     <= '0;
      cur_bits <= '0;
      v1       <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (seed_load) begin
        lfsr <= (prbs_seed == 7'h00) ? PRBS7_RESET_STATE : prbs_seed;
      end else if (in_valid && use_prbs) begin
        lfsr <= lfsr_next;
      end else begin
        lfsr <= lfsr;
      end
      if (in_valid) begin
        cur_bits <= word;
        snap     <= hist;
        hist     <= hist_next;
      end else begin
        cur_bits <= cur_bits;
        snap     <= snap;
        hist     <= hist;
      end
    end
  end

  for (genvar l = 0; l < numChannels; l++) begin : g_lane
    logic [2*estDepth-1:0]   lane_syms;
    logic signed [ACC_W-1:0] lane_acc;
    for (genvar k = 0; k < estDepth; k++) begin : g_tap
      assign lane_syms[2*k +: 2] = win[2*(HIST + l - k) +: 2];
    end
    chan_fir_lane #(
      .estBitwidth (estBitwidth),
      .estDepth    (estDepth),
      .accWidth    (ACC_W)
    ) u_lane (
      .syms (lane_syms),
      .est  (channel_est[l]),
      .acc  (lane_acc)
    );
    assign codes_next[l] = codeBitwidth'(code_conv(32'(lane_acc), codeBitwidth));
  end

  // stage 2: registered codes; outputs hold while no word is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      codes     <= '0;
      bits_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        codes    <= codes_next;
        bits_out <= cur_bits;
      end else begin
        codes    <= codes;
        bits_out <= bits_out;
      end
    end
  end

endmodule

// File: tb/tb_channel_code_gen.sv
// Scoreboard bench for channel_code_gen: serial-stream convolution model and recurrence-based PRBS7 model.
module tb_channel_code_gen;
  localparam int NC = 32;
  localparam int CW = 8;
  localparam int EB = 8;
  localparam int D  = 11;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic use_prbs;
  logic seed_load;
  logic [6:0] prbs_seed;
  logic [NC-1:0] bits_in;
  logic [NC-1:0][D-1:0][EB-1:0] channel_est;
  logic [NC-1:0][CW-1:0] codes;
  logic [NC-1:0] bits_out;
  logic out_valid;

  channel_code_gen #(.numChannels(NC), .codeBitwidth(CW), .estBitwidth(EB), .estDepth(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .use_prbs(use_prbs), .seed_load(seed_load),
    .prbs_seed(prbs_seed), .bits_in(bits_in), .channel_est(channel_est),
    .codes(codes), .bits_out(bits_out), .out_valid(out_valid));

  always #5 clk = ~clk;

  typedef struct {
    logic [NC-1:0][CW-1:0] codes;
    logic [NC-1:0]         bits;
    int                    cyc;
  } exp_t;

  exp_t sb[$];
  logic [NC-1:0][CW-1:0] got[$];
  bit ser[$];
  bit pb[$];
  bit dut_bits[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // PRBS model: x[n] = x[n-6] ^ x[n-7]; pb holds the last 7 bits, oldest first
  task automatic set_seed(input logic [6:0] s);
    logic [6:0] v;
    v = (s == 7'h00) ? 7'h01 : s;
    pb.delete();
    for (int i = 6; i >= 0; i--) pb.push_back(v[i]);
  endtask

  function automatic bit prbs_next();
    bit b;
    b = pb[1] ^ pb[0];
    pb.push_back(b);
    void'(pb.pop_front());
    return b;
  endfunction

  function automatic logic [CW-1:0] expect_code(input int n, input int lane);
    int sum;
    sum = 0;
    for (int k = 0; k < D; k++) begin
      if (n - k >= 0) sum += (ser[n-k] ? 1 : -1) * int'($signed(channel_est[lane][k]));
    end
`ifdef CHANNEL_CODE_GEN_SAT_EN
    if (sum > 127) sum = 127;
    if (sum < -128) sum = -128;
`endif
    return CW'(sum);
  endfunction

  task automatic send(input bit v, input bit up, input bit sl, input logic [6:0] seed, input logic [NC-1:0] b);
    exp_t e;
    logic [NC-1:0] w;
    int base;
    @(negedge clk);
    in_valid = v; use_prbs = up; seed_load = sl; prbs_seed = seed; bits_in = b;
    if (v) begin
      if (up) begin
        for (int l = 0; l < NC; l++) w[l] = prbs_next();
      end else begin
        w = b;
      end
      base = ser.size();
      for (int l = 0; l < NC; l++) ser.push_back(w[l]);
      for (int l = 0; l < NC; l++) e.codes[l] = expect_code(base + l, l);
      e.bits = w;
      e.cyc  = cyc + 2;
      sb.push_back(e);
    end
    if (sl) set_seed(seed);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0, 1'b0, 7'h00, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_pending", 256'(sb.size()), 256'd0);
    sb.delete();
    idle(1);
  endtask

  task automatic set_est_pattern(input int mode);
    for (int l = 0; l < NC; l++)
      for (int k = 0; k < D; k++)
        if (mode == 0) channel_est[l][k] = (k == 0) ? 8'd5 : EB'(10 - k);
        else if (mode == 1) channel_est[l][k] = 8'd127;
        else channel_est[l][k] = EB'($urandom_range(255, 0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    ser.delete();
    set_seed(7'h01);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor: pop and compare whenever the DUT presents a word
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 256'd1, 256'd0);
        end else begin
          e = sb.pop_front();
          chk("codes", codes, e.codes);
          chk("bits_out", 256'(bits_out), 256'(e.bits));
          chk("latency_cycle", 256'(cyc), 256'(e.cyc));
          got.push_back(codes);
          for (int l = 0; l < NC; l++) dut_bits.push_back(bits_out[l]);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] all50;
    logic [255:0] want;
    int mism;
    rst = 1'b1; in_valid = 1'b0; use_prbs = 1'b0; seed_load = 1'b0; prbs_seed = 7'h00; bits_in = '0;
    set_est_pattern(0);
    do_reset();
    @(negedge clk);
    chk("reset_out_valid", 256'(out_valid), 256'd0);
    chk("reset_codes", codes, 256'd0);
    chk("reset_bits_out", 256'(bits_out), 256'd0);

    // all-ones stream with the reference taps
    got.delete();
    for (int w = 0; w < 4; w++) send(1'b1, 1'b0, 1'b0, 7'h00, '1);
    idle(1);
    drain();
    for (int i = 0; i < NC; i++) all50[8*i +: 8] = 8'd50;
    if (got.size() == 4) begin
      chk("word0_lane0", 256'(got[0][0]), 256'd5);
      chk("word0_lane31", 256'(got[0][31]), 256'd50);
      chk("word3_all50", got[3], all50);
    end else begin
      chk("word_count_t1", 256'(got.size()), 256'd4);
    end

    // large taps: saturation or wrap
    set_est_pattern(1);
    got.delete();
    for (int w = 0; w < 3; w++) send(1'b1, 1'b0, 1'b0, 7'h00, '1);
    idle(1);
    drain();
`ifdef CHANNEL_CODE_GEN_SAT_EN
    want = 256'd127;
`else
    want = 256'd117;
`endif
    if (got.size() == 3) chk("steady_large_taps", 256'(got[2][5]), want);
    else chk("word_count_t2", 256'(got.size()), 256'd3);

    // random bits and taps with gaps 1,0,0,1,1,0,1
    set_est_pattern(2);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 7; i++) begin
        if (i == 0 || i == 3 || i == 4 || i == 6) send(1'b1, 1'b0, 1'b0, 7'h00, NC'($urandom));
        else send(1'b0, 1'b0, 1'b0, 7'h00, NC'($urandom));
      end
    end
    idle(1);
    drain();

    // PRBS7 from a zero seed (maps to 7'h01), after an unrelated seed load
    set_est_pattern(0);
    do_reset();
    send(1'b0, 1'b1, 1'b1, 7'h55, '0);
    send(1'b0, 1'b1, 1'b1, 7'h00, '0);
    dut_bits.delete();
    for (int w = 0; w < 9; w++) send(1'b1, 1'b1, 1'b0, 7'h00, NC'($urandom));
    idle(1);
    drain();
    mism = 0;
    if (dut_bits.size() == 9 * NC) begin
      for (int i = 0; i + 127 < dut_bits.size(); i++) if (dut_bits[i] != dut_bits[i+127]) mism++;
    end else begin
      mism = -1;
    end
    chk("prbs_period_127", 256'(mism), 256'd0);

    // mixed sources, random seed loads and gaps; history carries across switches
    set_est_pattern(2);
    for (int i = 0; i < 60; i++)
      send(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), ($urandom_range(7, 0) == 0),
           7'($urandom), NC'($urandom));
    idle(1);
    drain();

    // asynchronous reset with two words in flight
    set_est_pattern(0);
    send(1'b1, 1'b0, 1'b0, 7'h00, NC'($urandom));
    send(1'b1, 1'b0, 1'b0, 7'h00, NC'($urandom));
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 256'(out_valid), 256'd0);
    chk("midrst_codes", codes, 256'd0);
    sb.delete();
    ser.delete();
    set_seed(7'h01);
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    for (int w = 0; w < 2; w++) send(1'b1, 1'b0, 1'b0, 7'h00, '1);
    idle(1);
    drain();
    if (got.size() == 2) chk("post_rst_lane0", 256'(got[0][0]), 256'd5);
    else chk("word_count_t5", 256'(got.size()), 256'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
